// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - State type, size limit and round-robin helper for the Wishbone master arbiter.
package wb_arb_pkg;

   localparam int c_arb_max_masters = 8;

   typedef enum logic {ARB_IDLE, ARB_BUSY} t_arb_state;

   // Scan starts one past the previous owner so the previous owner is considered last.
   function automatic logic [c_arb_max_masters-1:0] f_rr_next(
      input logic [c_arb_max_masters-1:0] req,
      input logic [2:0]                   last,
      input int                           n
   );
      logic [c_arb_max_masters-1:0] gnt;
      logic                         found;
      logic [2:0]                   idx;
      gnt   = '0;
      found = 1'b0;
      for (int i = 1; i <= c_arb_max_masters; i++) begin
         if (i <= n) begin
            idx = 3'((int'(last) + i) % n);
            if (!found && req[idx]) begin
               gnt[idx] = 1'b1;
               found    = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/wishbone_pkg.sv
// rtl/wishbone_pkg.sv - Pipelined Wishbone request/response record types shared by masters and slaves.
package wishbone_pkg;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] dat;
   } t_wishbone_master_out;

   typedef struct packed {
      logic        ack;
      logic        err;
      logic        rty;
      logic        stall;
      logic [31:0] dat;
   } t_wishbone_master_in;

endpackage

// File: rtl/wb_rr_priority.sv
// rtl/wb_rr_priority.sv - Combinational round-robin picker: request vector and last owner to one-hot grant.
module wb_rr_priority
   import wb_arb_pkg::*;
#(
   parameter int g_num_masters = 2
) (
   input  logic [g_num_masters-1:0] req,
   input  logic [2:0]               last,
   output logic [g_num_masters-1:0] grant,
   output logic                     valid
);

   logic [c_arb_max_masters-1:0] req_ext;
   logic [c_arb_max_masters-1:0] gnt_ext;

   always_comb begin
      req_ext                    = '0;
      req_ext[g_num_masters-1:0] = req;
      gnt_ext                    = f_rr_next(req_ext, last, g_num_masters);
   end

   assign grant = gnt_ext[g_num_masters-1:0];
   assign valid = |gnt_ext;

endmodule

// File: rtl/wb_rr_master_arbiter.sv
// rtl/wb_rr_master_arbiter.sv - Round-robin whole-cycle arbiter of N Wishbone masters onto one slave.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_master_arbiter
   import wishbone_pkg::*;
   import wb_arb_pkg::*;
#(
   parameter int g_num_masters     = 2,
   parameter int g_max_outstanding = 15,
   parameter int g_timeout         = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  t_wishbone_master_out      m_i [g_num_masters],
   output t_wishbone_master_in       m_o [g_num_masters],
   output t_wishbone_master_out      s_o,
   input  t_wishbone_master_in       s_i,
   output logic [g_num_masters-1:0]  grant_o,
   output logic                      busy_o
);

   localparam int c_out_w = $clog2(g_max_outstanding + 1);

   t_arb_state               state, state_nxt;
   logic [g_num_masters-1:0] grant_q;
   logic [g_num_masters-1:0] pick;
   logic                     pick_valid;
   logic [g_num_masters-1:0] cyc_vec;
   logic [g_num_masters-1:0] req;
   logic [2:0]               last_q;
   logic [2:0]               gidx;
   logic [c_out_w-1:0]       outstanding;
   t_wishbone_master_out     mg;
   logic                     released;
   logic                     resp;
   logic                     fwd;
   logic                     at_max;
   logic                     accept;
   logic                     timeout_hit;
   logic                     drop;

   always_comb begin
      mg   = '0;
      gidx = '0;
      for (int k = 0; k < g_num_masters; k++) begin
         cyc_vec[k] = m_i[k].cyc;
         if (grant_q[k]) begin
            mg   = m_i[k];
            gidx = 3'(k);
         end
      end
   end

   assign released = (state == ARB_BUSY) && !mg.cyc;
   assign resp     = s_i.ack | s_i.err | s_i.rty;
   assign at_max   = (outstanding == c_out_w'(g_max_outstanding));
   assign fwd      = (outstanding != '0) && !released;
   assign drop     = released | timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int c_wd_w = $clog2(g_timeout + 1);

   logic [c_wd_w-1:0]        wd_cnt;
   logic [g_num_masters-1:0] lock_q;

   assign timeout_hit = (state == ARB_BUSY) && !released && (outstanding != '0) && !resp &&
                        (wd_cnt == c_wd_w'(g_timeout - 1));
   assign req         = cyc_vec & ~lock_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || state != ARB_BUSY || resp || outstanding == '0 || drop)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end

   // A timed-out master stays locked out until it drops cyc or somebody else is granted.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         lock_q <= '0;
      else if (timeout_hit)
         lock_q <= grant_q;
      else if (state == ARB_IDLE && pick_valid)
         lock_q <= '0;
      else
         lock_q <= lock_q & cyc_vec;
   end
`else
   localparam int c_unused_timeout = g_timeout;

   assign timeout_hit = 1'b0;
   assign req         = cyc_vec;
`endif

   wb_rr_priority #(
      .g_num_masters(g_num_masters)
   ) u_priority (
      .req  (req),
      .last (last_q),
      .grant(pick),
      .valid(pick_valid)
   );

   always_comb begin
      s_o = '0;
      if (state == ARB_BUSY) begin
         s_o     = mg;
         s_o.cyc = !drop;
         s_o.stb = mg.stb && !at_max && !drop;
      end
   end

   assign accept = s_o.stb && !s_i.stall;

   always_comb begin
      for (int k = 0; k < g_num_masters; k++) begin
         m_o[k].ack   = 1'b0;
         m_o[k].err   = 1'b0;
         m_o[k].rty   = 1'b0;
         m_o[k].stall = 1'b1;
         m_o[k].dat   = '0;
         if (state == ARB_BUSY && grant_q[k]) begin
            m_o[k].stall = s_i.stall | at_max;
            m_o[k].ack   = s_i.ack & fwd;
            m_o[k].err   = (s_i.err & fwd) | timeout_hit;
            m_o[k].rty   = s_i.rty & fwd;
            m_o[k].dat   = s_i.dat;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == ARB_IDLE) begin
         if (pick_valid)
            state_nxt = ARB_BUSY;
      end else begin
         if (drop)
            state_nxt = ARB_IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= ARB_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant_q     <= '0;
         last_q      <= 3'(g_num_masters - 1);
         outstanding <= '0;
      end else if (state == ARB_IDLE) begin
         outstanding <= '0;
         if (pick_valid)
            grant_q <= pick;
      end else if (drop) begin
         grant_q     <= '0;
         last_q      <= gidx;
         outstanding <= '0;
      end else if (accept && !(resp && fwd)) begin
         outstanding <= outstanding + 1'b1;
      end else if (!accept && resp && fwd) begin
         outstanding <= outstanding - 1'b1;
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = (state == ARB_BUSY);

endmodule

// File: tb/tb_wb_rr_master_arbiter.sv
// tb/tb_wb_rr_master_arbiter.sv - Directed vector-table bench for wb_rr_master_arbiter.
module tb_wb_rr_master_arbiter;
   import wishbone_pkg::*;

   localparam int NM = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   t_wishbone_master_out m_i [NM];
   t_wishbone_master_in  m_o [NM];
   t_wishbone_master_out s_o;
   t_wishbone_master_in  s_i;
   logic [NM-1:0]        grant;
   logic                 busy;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   wb_rr_master_arbiter #(
      .g_num_masters    (NM),
      .g_max_outstanding(15),
      .g_timeout        (16)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .m_i    (m_i),
      .m_o    (m_o),
      .s_o    (s_o),
      .s_i    (s_i),
      .grant_o(grant),
      .busy_o (busy)
   );

   typedef struct {
      logic        rst;
      logic        m0c, m0s, m1c, m1s, ack;
      logic [31:0] sdat;
      logic [1:0]  e_grant;
      logic        e_cyc, e_stb, e_st0, e_ack0, e_st1, e_ack1;
      logic [31:0] e_dat0, e_dat1, e_adr;
      logic [3:0]  e_out;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic r, m0c, m0s, m1c, m1s, ak, input logic [31:0] sd,
                               input logic [1:0] g, input logic c, s, st0, a0, st1, a1,
                               input logic [31:0] d0, d1, adr, input logic [3:0] o);
      vec_t v;
      v.rst = r; v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s; v.ack = ak; v.sdat = sd;
      v.e_grant = g; v.e_cyc = c; v.e_stb = s; v.e_st0 = st0; v.e_ack0 = a0; v.e_st1 = st1;
      v.e_ack1 = a1; v.e_dat0 = d0; v.e_dat1 = d1; v.e_adr = adr; v.e_out = o;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, m0c, m0s, m1c, m1s, ak, input logic [31:0] sd);
      rst          = r;
      m_i[0].cyc   = m0c; m_i[0].stb = m0s; m_i[0].we = 1'b1; m_i[0].sel = 4'hF;
      m_i[0].adr   = 32'h100; m_i[0].dat = 32'hD000;
      m_i[1].cyc   = m1c; m_i[1].stb = m1s; m_i[1].we = 1'b0; m_i[1].sel = 4'hF;
      m_i[1].adr   = 32'h200; m_i[1].dat = 32'hD111;
      s_i.ack      = ak; s_i.err = 1'b0; s_i.rty = 1'b0; s_i.stall = 1'b0; s_i.dat = sd;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int accepted;
      drive(1, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);

      // Test 1: pipelined 4-word write by m0, one ack per clock
      vt.push_back(mk(1,0,0,0,0,0,0,      0,0,0,1,0,1,0, 0,0,0,     0));
      vt.push_back(mk(0,1,1,0,0,0,0,      0,0,0,1,0,1,0, 0,0,0,     0));
      vt.push_back(mk(0,1,1,0,0,0,0,      1,1,1,0,0,1,0, 0,0,'h100, 0));
      vt.push_back(mk(0,1,1,0,0,1,'hA001, 1,1,1,0,1,1,0, 'hA001,0,'h100, 1));
      vt.push_back(mk(0,1,1,0,0,1,'hA002, 1,1,1,0,1,1,0, 'hA002,0,'h100, 1));
      vt.push_back(mk(0,1,1,0,0,1,'hA003, 1,1,1,0,1,1,0, 'hA003,0,'h100, 1));
      vt.push_back(mk(0,1,0,0,0,1,'hA004, 1,1,0,0,1,1,0, 'hA004,0,'h100, 1));
      vt.push_back(mk(0,0,0,0,0,0,0,      1,0,0,0,0,1,0, 0,0,'h100, 0));
      vt.push_back(mk(0,0,0,0,0,0,0,      0,0,0,1,0,1,0, 0,0,0,     0));
      // Test 2: simultaneous requests, alternating ownership
      vt.push_back(mk(1,0,0,0,0,0,0,      0,0,0,1,0,1,0, 0,0,0,     0));
      vt.push_back(mk(0,1,0,1,0,0,0,      0,0,0,1,0,1,0, 0,0,0,     0));
      vt.push_back(mk(0,1,1,1,1,0,0,      1,1,1,0,0,1,0, 0,0,'h100, 0));
      vt.push_back(mk(0,1,1,1,1,1,'hB001, 1,1,1,0,1,1,0, 'hB001,0,'h100, 1));
      vt.push_back(mk(0,1,0,1,1,1,'hB002, 1,1,0,0,1,1,0, 'hB002,0,'h100, 1));
      vt.push_back(mk(0,0,0,1,1,0,0,      1,0,0,0,0,1,0, 0,0,'h100, 0));
      vt.push_back(mk(0,1,0,1,1,0,0,      0,0,0,1,0,1,0, 0,0,0,     0));
      vt.push_back(mk(0,1,0,1,1,0,0,      2,1,1,1,0,0,0, 0,0,'h200, 0));
      vt.push_back(mk(0,1,0,1,1,1,'hC001, 2,1,1,1,0,0,1, 0,'hC001,'h200, 1));
      vt.push_back(mk(0,1,0,1,0,1,'hC002, 2,1,0,1,0,0,1, 0,'hC002,'h200, 1));
      vt.push_back(mk(0,1,0,0,0,0,0,      2,0,0,1,0,0,0, 0,0,'h200, 0));
      vt.push_back(mk(0,1,0,1,0,0,0,      0,0,0,1,0,1,0, 0,0,0,     0));
      vt.push_back(mk(0,0,0,0,0,0,0,      1,0,0,0,0,1,0, 0,0,'h100, 0));
      vt.push_back(mk(0,0,0,0,0,0,0,      0,0,0,1,0,1,0, 0,0,0,     0));

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         drive(vt[i].rst, vt[i].m0c, vt[i].m0s, vt[i].m1c, vt[i].m1s, vt[i].ack, vt[i].sdat);
         #1;
         check($sformatf("v%0d grant", i), 32'(grant), 32'(vt[i].e_grant));
         check($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].e_grant != 0));
         check($sformatf("v%0d s_cyc", i), 32'(s_o.cyc), 32'(vt[i].e_cyc));
         check($sformatf("v%0d s_stb", i), 32'(s_o.stb), 32'(vt[i].e_stb));
         check($sformatf("v%0d s_adr", i), s_o.adr, vt[i].e_adr);
         check($sformatf("v%0d m0_stall", i), 32'(m_o[0].stall), 32'(vt[i].e_st0));
         check($sformatf("v%0d m0_ack", i), 32'(m_o[0].ack), 32'(vt[i].e_ack0));
         check($sformatf("v%0d m1_stall", i), 32'(m_o[1].stall), 32'(vt[i].e_st1));
         check($sformatf("v%0d m1_ack", i), 32'(m_o[1].ack), 32'(vt[i].e_ack1));
         check($sformatf("v%0d m0_dat", i), m_o[0].dat, vt[i].e_dat0);
         check($sformatf("v%0d m1_dat", i), m_o[1].dat, vt[i].e_dat1);
         check($sformatf("v%0d outstanding", i), 32'(dut.outstanding), 32'(vt[i].e_out));
      end

      // Test 3: silent slave, outstanding limit of 15
      apply_reset();
      accepted = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         drive(0, 1, 1, 0, 0, 0, 0);
         #1;
         if (!m_o[0].stall) accepted++;
      end
      check("t3 accepted", 32'(accepted), 32'd15);
      check("t3 stall at max", 32'(m_o[0].stall), 32'd1);
      check("t3 stb gated", 32'(s_o.stb), 32'd0);
      @(negedge clk);
      drive(0, 1, 1, 0, 0, 1, 'h33);
      #1;
      check("t3 stall during ack", 32'(m_o[0].stall), 32'd1);
      check("t3 ack fwd", 32'(m_o[0].ack), 32'd1);
      @(negedge clk);
      drive(0, 1, 0, 0, 0, 0, 0);
      #1;
      check("t3 stall after ack", 32'(m_o[0].stall), 32'd0);
      check("t3 outstanding", 32'(dut.outstanding), 32'd14);

      // Test 4: accept and ack in the same clock, then spurious ack
      apply_reset();
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);
      @(negedge clk); drive(0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(0, 1, 1, 0, 0, 1, 32'(i));
         #1;
         check($sformatf("t4 out c%0d", i), 32'(dut.outstanding), 32'd1);
         check($sformatf("t4 ack c%0d", i), 32'(m_o[0].ack), 32'd1);
      end
      @(negedge clk); drive(0, 1, 0, 0, 0, 1, 0);
      #1 check("t4 last ack", 32'(m_o[0].ack), 32'd1);
      @(negedge clk); drive(0, 1, 0, 0, 0, 1, 'h55);
      #1;
      check("t4 spurious m0", 32'(m_o[0].ack), 32'd0);
      check("t4 spurious m1", 32'(m_o[1].ack), 32'd0);
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);
      #1 check("t4 out zero", 32'(dut.outstanding), 32'd0);

      // Test 5: m1 aborts with 3 outstanding; then reset in mid-cycle
      apply_reset();
      @(negedge clk); drive(0, 0, 0, 1, 0, 0, 0);
      repeat (3) begin
         @(negedge clk); drive(0, 0, 0, 1, 1, 0, 0);
      end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t5 s_cyc drop", 32'(s_o.cyc), 32'd0);
      check("t5 grant held", 32'(grant), 32'd2);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); drive(0, 0, 0, 0, 0, 1, 'h77);
         #1;
         check($sformatf("t5 grant idle %0d", i), 32'(grant), 32'd0);
         check($sformatf("t5 late m0 %0d", i), 32'(m_o[0].ack), 32'd0);
         check($sformatf("t5 late m1 %0d", i), 32'(m_o[1].ack), 32'd0);
      end
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);
      @(negedge clk); drive(0, 1, 1, 0, 0, 0, 0);
      @(negedge clk); drive(1, 1, 1, 0, 0, 0, 0);
      #1 check("t5 cyc before rst edge", 32'(s_o.cyc), 32'd1);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t5 rst s_cyc", 32'(s_o.cyc), 32'd0);
      check("t5 rst grant", 32'(grant), 32'd0);
      check("t5 rst out", 32'(dut.outstanding), 32'd0);

      // Test 6: slave silent after one accepted strobe
      apply_reset();
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);
      @(negedge clk); drive(0, 1, 1, 0, 0, 0, 0);
`ifdef WB_ARB_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);
         #1 check($sformatf("t6 err k%0d", k), 32'(m_o[0].err), 32'(k == 16));
      end
      check("t6 s_cyc at timeout", 32'(s_o.cyc), 32'd0);
      @(negedge clk);
      #1;
      check("t6 busy after", 32'(busy), 32'd0);
      check("t6 grant after", 32'(grant), 32'd0);
      @(negedge clk);
      #1 check("t6 locked out", 32'(grant), 32'd0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1 check("t6 regrant", 32'(grant), 32'd1);
`else
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);
      repeat (1000) @(negedge clk);
      #1;
      check("t6 grant held", 32'(grant), 32'd1);
      check("t6 busy held", 32'(busy), 32'd1);
      check("t6 no err", 32'(m_o[0].err), 32'd0);
      check("t6 s_cyc held", 32'(s_o.cyc), 32'd1);
      check("t6 out held", 32'(dut.outstanding), 32'd1);
`endif
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1 check("t6 final idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
